// File: rtl/agc_pkg.sv
// agc_pkg: shared definitions for the AGC level controller.
//   agc_state_t        - controller FSM state encoding
//   AGC_* localparams  - default sample width, settle time, window length, thresholds
//   cnt_width()        - bit width for a down-counter that is loaded with n-1
package agc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_LOCKED  = 3'd4
    } agc_state_t;

    localparam int AGC_DATA_W        = 8;
    localparam int AGC_SETTLE_CYCLES = 16;
    localparam int AGC_WINDOW_LEN    = 32;
    localparam int AGC_TH_HI         = 96;
    localparam int AGC_TH_LO         = 48;
    localparam int AGC_ADJ_COUNT_W   = 4;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/agc_if.sv
// agc_if: signal bundle between the AGC level controller and its environment.
//   master modport: environment side (drives start, ADC samples, search_done)
//   slave modport : controller side (drives adjust, up_dn, busy, locked, adj_count)
interface agc_if #(
    parameter int DATA_W = 8
) ();
    logic              start;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              search_done;
    logic              adjust;
    logic              up_dn;
    logic              busy;
    logic              locked;
    logic [3:0]        adj_count;

    modport master (
        output start, adc_valid, adc_data, search_done,
        input  adjust, up_dn, busy, locked, adj_count
    );

    modport slave (
        input  start, adc_valid, adc_data, search_done,
        output adjust, up_dn, busy, locked, adj_count
    );
endinterface

// File: rtl/agc_peak_detect.sv
// agc_peak_detect: saturating magnitude, running peak and measurement window counter.
//   clk, rst       - clock, async active-high reset
//   clear_i        - clears peak and reloads the window counter (wins over sample_en_i)
//   sample_en_i    - a valid sample to fold into the current window
//   data_i         - two's-complement sample
//   peak_o         - largest magnitude seen since the last clear
//   window_done_o  - high on the cycle the WINDOW_LEN-th sample is taken
module agc_peak_detect
    import agc_pkg::*;
#(
    parameter int DATA_W     = AGC_DATA_W,
    parameter int WINDOW_LEN = AGC_WINDOW_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] peak_o,
    output logic              window_done_o
);
    localparam int WIN_W = cnt_width(WINDOW_LEN);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;

    // The most negative code has no positive twin; clamp it to full scale.
    always_comb begin
        if (data_i == MOST_NEG)
            mag = MAX_POS;
        else if (data_i[DATA_W-1])
            mag = ~data_i + DATA_W'(1);
        else
            mag = data_i;
    end

    assign window_done_o = sample_en_i && (win_cnt_q == '0);

    always_comb begin
        peak_d    = peak_q;
        win_cnt_d = win_cnt_q;
        if (clear_i) begin
            peak_d    = '0;
            win_cnt_d = WIN_W'(WINDOW_LEN - 1);
        end else if (sample_en_i) begin
            peak_d    = (mag > peak_q) ? mag : peak_q;
            win_cnt_d = (win_cnt_q == '0) ? WIN_W'(WINDOW_LEN - 1) : win_cnt_q - WIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q    <= '0;
            win_cnt_q <= '0;
        end else begin
            peak_q    <= peak_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/agc_level_ctrl.sv
// agc_level_ctrl: measures ADC peak level per window and steps the external gain
// search up or down until the level sits inside [TH_LO, TH_HI] or the search reports done.
//   clk, RESET - clock, async active-high reset
//   bus        - agc_if slave: start/adc_valid/adc_data/search_done in,
//                adjust/up_dn/busy/locked/adj_count out
// Build option AGC_RETRACK_EN: LOCKED keeps measuring and re-decides each window.
//
// state      | meaning
// IDLE       | waiting for start
// SETTLE     | letting the new gain settle, samples ignored
// MEASURE    | folding valid samples into the window peak
// DECIDE     | one cycle: lock, or request a gain step
// LOCKED     | level in band (or search done)
module agc_level_ctrl
    import agc_pkg::*;
#(
    parameter int DATA_W        = AGC_DATA_W,
    parameter int SETTLE_CYCLES = AGC_SETTLE_CYCLES,
    parameter int WINDOW_LEN    = AGC_WINDOW_LEN,
    parameter int TH_HI         = AGC_TH_HI,
    parameter int TH_LO         = AGC_TH_LO
) (
    input logic  clk,
    input logic  RESET,
    agc_if.slave bus
);
    localparam int SET_W = cnt_width(SETTLE_CYCLES);

    agc_state_t        state_q, state_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              adjust_q, adjust_d;
    logic              up_dn_q, up_dn_d;
    logic [3:0]        adj_count_q, adj_count_d;
    logic [DATA_W-1:0] peak;
    logic              window_done;
    logic              sample_en;
    logic              peak_clear;
    logic              too_hot, too_cold;
    logic              search_hit;
    logic              issue_adj;
    logic              busy, locked;

`ifdef AGC_RETRACK_EN
    // DECIDE is only reached from MEASURE or LOCKED; this remembers which.
    logic retrack_q, retrack_d;
    assign retrack_d  = (state_q == ST_LOCKED);
    assign search_hit = bus.search_done && !retrack_q;
    assign sample_en  = bus.adc_valid && ((state_q == ST_MEASURE) || (state_q == ST_LOCKED));
`else
    assign search_hit = bus.search_done;
    assign sample_en  = bus.adc_valid && (state_q == ST_MEASURE);
`endif

    assign peak_clear = bus.start || (state_q == ST_DECIDE);
    assign too_hot    = int'(peak) > TH_HI;
    assign too_cold   = int'(peak) < TH_LO;
    assign issue_adj  = (state_q == ST_DECIDE) && !bus.start && !search_hit && (too_hot || too_cold);

    agc_peak_detect #(
        .DATA_W     (DATA_W),
        .WINDOW_LEN (WINDOW_LEN)
    ) u_peak (
        .clk           (clk),
        .rst           (RESET),
        .clear_i       (peak_clear),
        .sample_en_i   (sample_en),
        .data_i        (bus.adc_data),
        .peak_o        (peak),
        .window_done_o (window_done)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            adjust_q     <= 1'b0;
            up_dn_q      <= 1'b0;
            adj_count_q  <= '0;
`ifdef AGC_RETRACK_EN
            retrack_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            adjust_q     <= adjust_d;
            up_dn_q      <= up_dn_d;
            adj_count_q  <= adj_count_d;
`ifdef AGC_RETRACK_EN
            retrack_q    <= retrack_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        if (bus.start) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SETTLE: begin
                    if (settle_cnt_q == '0)
                        state_d = ST_MEASURE;
                    else
                        settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
                ST_MEASURE: begin
                    if (window_done)
                        state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (issue_adj) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
`ifdef AGC_RETRACK_EN
                    if (window_done)
                        state_d = ST_DECIDE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_DECIDE);
`ifdef AGC_RETRACK_EN
        // A re-check from LOCKED keeps locked high until it actually falls out of band.
        locked = (state_q == ST_LOCKED) || ((state_q == ST_DECIDE) && retrack_q);
`else
        locked = (state_q == ST_LOCKED);
`endif
        adjust_d = issue_adj;
        up_dn_d  = issue_adj ? !too_hot : up_dn_q;
        if (bus.start)
            adj_count_d = '0;
        else if (issue_adj && (adj_count_q != 4'hF))
            adj_count_d = adj_count_q + 4'd1;
        else
            adj_count_d = adj_count_q;
    end

    assign bus.adjust    = adjust_q;
    assign bus.up_dn     = up_dn_q;
    assign bus.busy      = busy;
    assign bus.locked    = locked;
    assign bus.adj_count = adj_count_q;

endmodule

// File: tb/tb_agc_level_ctrl.sv
// tb_agc_level_ctrl: directed bench for agc_level_ctrl with a cycle-level
// behavioural model checked every cycle, plus hand-computed timing checks.
// Build option AGC_RETRACK_EN enables the re-tracking scenario.
module tb_agc_level_ctrl;
    localparam int DW  = 8;
    localparam int SET = 16;
    localparam int WIN = 32;
    localparam int HI  = 96;
    localparam int LO  = 48;

    localparam int P_IDLE    = 0;
    localparam int P_SETTLE  = 1;
    localparam int P_MEASURE = 2;
    localparam int P_DECIDE  = 3;
    localparam int P_LOCKED  = 4;

    logic clk = 1'b0;
    logic RESET;

    agc_if #(.DATA_W(DW)) bus ();

    agc_level_ctrl dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_left, m_samples, m_peak, m_adj, m_dir, m_count;
    bit m_from_lock;
    bit cmp_on = 0;

    function automatic int abs_sat(input int v);
        if (v == -(1 << (DW - 1)))
            return (1 << (DW - 1)) - 1;
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step_gain(input int dir);
        m_adj   = 1;
        m_dir   = dir;
        if (m_count < 15) m_count++;
        m_phase = P_SETTLE;
        m_left  = SET;
    endtask

    task automatic model_sample(input bit from_lock);
        int v;
        if (bus.adc_valid) begin
            v = $signed(bus.adc_data);
            if (abs_sat(v) > m_peak) m_peak = abs_sat(v);
            m_samples++;
            if (m_samples == WIN) begin
                m_phase     = P_DECIDE;
                m_from_lock = from_lock;
                m_samples   = 0;
            end
        end
    endtask

    task automatic model_decide();
        if (bus.search_done && !m_from_lock)
            m_phase = P_LOCKED;
        else if (m_peak > HI)
            model_step_gain(0);
        else if (m_peak < LO)
            model_step_gain(1);
        else
            m_phase = P_LOCKED;
        m_peak    = 0;
        m_samples = 0;
    endtask

    always @(posedge clk or posedge RESET) begin
        if (RESET) begin
            m_phase = P_IDLE; m_left = 0; m_samples = 0; m_peak = 0;
            m_adj = 0; m_dir = 0; m_count = 0; m_from_lock = 0;
        end else begin
            m_adj = 0;
            if (bus.start) begin
                m_phase = P_SETTLE; m_left = SET; m_samples = 0; m_peak = 0;
                m_count = 0; m_from_lock = 0;
            end else begin
                case (m_phase)
                    P_SETTLE: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_MEASURE;
                    end
                    P_MEASURE: model_sample(1'b0);
                    P_DECIDE:  model_decide();
                    P_LOCKED: begin
`ifdef AGC_RETRACK_EN
                        model_sample(1'b1);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("adjust",    int'(bus.adjust),    m_adj);
            chk("up_dn",     int'(bus.up_dn),     m_dir);
            chk("busy",      int'(bus.busy),
                int'(m_phase == P_SETTLE || m_phase == P_MEASURE || m_phase == P_DECIDE));
            chk("locked",    int'(bus.locked),
                int'(m_phase == P_LOCKED || (m_phase == P_DECIDE && m_from_lock)));
            chk("adj_count", int'(bus.adj_count), m_count);
        end
    end

    // ---------------- stimulus ----------------
    int mode = 0;
    int cval = 0;
    bit alt_ph = 0;
    int alt_idx = 0;
    bit pend_start = 0;
    int alt_vals[4] = '{-96, 50, 96, -20};

    task automatic drive();
        if (mode == 0) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = DW'(cval);
        end else begin
            bus.adc_valid = alt_ph;
            if (alt_ph) begin
                bus.adc_data = DW'(alt_vals[alt_idx % 4]);
                alt_idx++;
            end else begin
                bus.adc_data = DW'(-128);
            end
            alt_ph = !alt_ph;
        end
    endtask

    // One clock: inputs change on the falling edge, checks run 2 time units after the rising edge.
    task automatic tick();
        @(negedge clk);
        bus.start  = pend_start;
        pend_start = 0;
        drive();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int pulses;
        bit seen;

        RESET = 1'b1;
        bus.start = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = '0; bus.search_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RESET  = 1'b0;
        cmp_on = 1;
        tick();
        chk("rst_busy",   int'(bus.busy),      0);
        chk("rst_locked", int'(bus.locked),    0);
        chk("rst_count",  int'(bus.adj_count), 0);
        chk("rst_adjust", int'(bus.adjust),    0);

        // Constant 70: in band, locks after settle + one window + decide.
        mode = 0; cval = 70; pulses = 0;
        pend_start = 1; tick();
        for (int i = 1; i <= 49; i++) begin
            tick();
            pulses += int'(bus.adjust);
            if (i == 48) begin
                chk("t1_peak_model", m_peak, 70);
                chk("t1_locked_early", int'(bus.locked), 0);
                chk("t1_busy_decide",  int'(bus.busy),   1);
            end
            if (i == 49) begin
                chk("t1_locked", int'(bus.locked),    1);
                chk("t1_busy",   int'(bus.busy),      0);
                chk("t1_count",  int'(bus.adj_count), 0);
            end
        end
        repeat (20) begin tick(); pulses += int'(bus.adjust); end
        chk("t1_pulses", pulses, 0);
        chk("t1_lock_held", int'(bus.locked), 1);

        // Most-negative code: saturated magnitude 127 lowers gain every window; count saturates.
        cval = -128; pulses = 0;
        pend_start = 1; tick();
        for (int i = 1; i <= 840; i++) begin
            tick();
            pulses += int'(bus.adjust);
            if (i == 48) begin
                chk("t2_peak_model", m_peak, 127);
                chk("t2_no_adj_yet", int'(bus.adjust), 0);
            end
            if (i == 49) begin
                chk("t2_adjust", int'(bus.adjust),    1);
                chk("t2_up_dn",  int'(bus.up_dn),     0);
                chk("t2_count",  int'(bus.adj_count), 1);
            end
            if (i == 50) chk("t2_pulse_width", int'(bus.adjust), 0);
        end
        chk("t2_sat_count", int'(bus.adj_count), 15);
        chk("t2_pulses", pulses, 17);

        // Restart while busy clears the count; start landing on DECIDE suppresses the pulse.
        pend_start = 1; tick();
        chk("t2b_count_clr", int'(bus.adj_count), 0);
        repeat (48) tick();
        pend_start = 1; tick();
        chk("t2b_no_adjust", int'(bus.adjust),    0);
        chk("t2b_count",     int'(bus.adj_count), 0);
        chk("t2b_busy",      int'(bus.busy),      1);

        // Weak signal: three up steps, then search_done forces lock.
        cval = 10; pulses = 0;
        pend_start = 1; tick();
        for (int i = 0; i < 400 && pulses < 3; i++) begin
            tick();
            pulses += int'(bus.adjust);
        end
        chk("t3_three_pulses", pulses, 3);
        chk("t3_up_dn", int'(bus.up_dn), 1);
        bus.search_done = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            pulses += int'(bus.adjust);
            seen = bus.locked;
        end
        chk("t3_locked", int'(seen), 1);
        chk("t3_count", int'(bus.adj_count), 3);
        chk("t3_pulses_total", pulses, 3);
        bus.search_done = 1'b0;

        // Valid every 2nd cycle, peak exactly TH_HI (in band); invalid slots carry -128.
        mode = 1; alt_ph = 0; alt_idx = 0;
        pend_start = 1; tick();
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 79) begin
                chk("t4_peak_model", m_peak, 96);
                chk("t4_locked_early", int'(bus.locked), 0);
                chk("t4_busy", int'(bus.busy), 1);
            end
            if (i == 80) begin
                chk("t4_locked", int'(bus.locked),    1);
                chk("t4_count",  int'(bus.adj_count), 0);
            end
        end

        // Reset mid-MEASURE: outputs clear at once, nothing stale follows, fresh settle after start.
        mode = 0; cval = 10;
        pend_start = 1; tick();
        repeat (69) tick();
        @(negedge clk);
        RESET = 1'b1;
        #1;
        chk("t5_busy",   int'(bus.busy),      0);
        chk("t5_locked", int'(bus.locked),    0);
        chk("t5_count",  int'(bus.adj_count), 0);
        chk("t5_up_dn",  int'(bus.up_dn),     0);
        chk("t5_adjust", int'(bus.adjust),    0);
        repeat (3) tick();
        RESET = 1'b0;
        pulses = 0;
        repeat (60) begin tick(); pulses += int'(bus.adjust); end
        chk("t5_no_stale", pulses, 0);
        chk("t5_idle", int'(bus.busy), 0);
        pend_start = 1; tick();
        for (int i = 1; i <= 49; i++) begin
            tick();
            if (i == 48) chk("t5_adj_early", int'(bus.adjust), 0);
            if (i == 49) chk("t5_adj_first", int'(bus.adjust), 1);
        end

`ifdef AGC_RETRACK_EN
        // Lock at 70, then the level jumps to 120: lock drops and gain steps down.
        cval = 70;
        pend_start = 1; tick();
        repeat (49) tick();
        chk("t6_locked", int'(bus.locked), 1);
        repeat (40) tick();
        chk("t6_still_locked", int'(bus.locked), 1);
        cval = 120; seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            seen = bus.adjust;
        end
        chk("t6_adjust_seen", int'(seen), 1);
        chk("t6_up_dn", int'(bus.up_dn), 0);
        chk("t6_unlocked", int'(bus.locked), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
